// File: rtl/input_action_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_action_pkg
// Description : Shared button indices, action codes, scheduler FSM states and
//               the fixed-priority action picker for input_action_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package input_action_pkg;

   // Bit positions inside the decoded controller snapshot
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Action codes; the code doubles as the index of its pending bit
   localparam logic [2:0] ACT_NONE      = 3'd0;
   localparam logic [2:0] ACT_ROT_CW    = 3'd1;
   localparam logic [2:0] ACT_ROT_CCW   = 3'd2;
   localparam logic [2:0] ACT_LEFT      = 3'd3;
   localparam logic [2:0] ACT_RIGHT     = 3'd4;
   localparam logic [2:0] ACT_SOFT_DROP = 3'd5;
   localparam logic [2:0] ACT_HARD_DROP = 3'd6;
   localparam logic [2:0] ACT_START     = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } sched_state_t;

   // Highest-priority pending action: START, HARD_DROP, ROT_CW, ROT_CCW,
   // LEFT, RIGHT, SOFT_DROP. Not simply numeric order, hence the chain.
   function automatic logic [2:0] pick_action(input logic [7:1] pend);
      logic [2:0] code;
      code = ACT_NONE;
      if (pend[ACT_START])          code = ACT_START;
      else if (pend[ACT_HARD_DROP]) code = ACT_HARD_DROP;
      else if (pend[ACT_ROT_CW])    code = ACT_ROT_CW;
      else if (pend[ACT_ROT_CCW])   code = ACT_ROT_CCW;
      else if (pend[ACT_LEFT])      code = ACT_LEFT;
      else if (pend[ACT_RIGHT])     code = ACT_RIGHT;
      else if (pend[ACT_SOFT_DROP]) code = ACT_SOFT_DROP;
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_repeat_counter.sv
`default_nettype none
// ============================================================================
// Module      : input_repeat_counter
// Description : Delayed auto-shift / auto-repeat counter for one held button.
//               Counts polls while held; fires at DAS_POLLS, then every
//               ARR_POLLS polls. ARR_POLLS must not exceed DAS_POLLS.
// Revision    : 1.0 - initial release
// ============================================================================
module input_repeat_counter #(
   parameter int DAS_POLLS = 16,
   parameter int ARR_POLLS = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic held,
   input  logic pressed,
   input  logic inhibit,
   output logic repeat_evt
);

   localparam int            CW       = $clog2(DAS_POLLS + 1);
   localparam logic [CW-1:0] C_FIRE   = CW'(DAS_POLLS - 1);
   localparam logic [CW-1:0] C_RELOAD = CW'(DAS_POLLS - ARR_POLLS);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Advance only on poll ticks; a fresh press, a release or an inhibit restarts the delay
   always_comb begin
      count_d    = count_q;
      repeat_evt = 1'b0;
      if (tick) begin
         if (pressed || !held || inhibit) begin
            count_d = '0;
         end else if (count_q == C_FIRE) begin
            repeat_evt = 1'b1;
            count_d    = C_RELOAD;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule
`default_nettype wire

// File: rtl/input_action_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : input_action_scheduler
// Description : Turns polled gamepad snapshots into a valid/ready stream of
//               game actions: press-edge detection, DAS/ARR auto-repeat on
//               Down/Left/Right, one coalescing pending bit per action and a
//               fixed-priority single-entry offer stage.
//               Optional pause feature: define INPUT_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module input_action_scheduler #(
   parameter int DAS_POLLS = 16,
   parameter int ARR_POLLS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] buttons,
   input  logic       buttons_valid,
   output logic       action_valid,
   output logic [2:0] action_code,
   input  logic       action_ready,
   output logic       paused
);

   import input_action_pkg::*;

   sched_state_t state_q, state_d;
   logic [7:0]   prev_buttons_q, prev_buttons_d;
   logic [7:1]   pending_q, pending_d;
   logic         action_valid_q, action_valid_d;
   logic [2:0]   action_code_q, action_code_d;

   logic [7:0]   w_press;
   logic [7:1]   w_event;
   logic [7:1]   w_offer_mask;
   logic         w_handshake;
   logic         w_pause_now;
   logic         w_lr_both;
   logic         w_rep_down, w_rep_left, w_rep_right;
   logic         w_unused_select;

   // Press edges exist only on strobe cycles
   always_comb begin
      w_press        = buttons_valid ? (buttons & ~prev_buttons_q) : 8'h00;
      prev_buttons_d = buttons_valid ? buttons : prev_buttons_q;
   end

   assign w_unused_select = w_press[BTN_SELECT];
   assign w_lr_both       = buttons[BTN_LEFT] & buttons[BTN_RIGHT];

`ifdef INPUT_PAUSE_EN
   logic paused_q, paused_d;

   // Start press flips pause on the same edge its pending bit is set
   always_comb begin
      paused_d = paused_q ^ w_press[BTN_START];
   end

   // Events and pending state are gated by the pause state taking effect on this edge
   assign w_pause_now = paused_d;
   assign paused      = paused_q;

   // Pause register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) paused_q <= 1'b0;
      else       paused_q <= paused_d;
   end
`else
   assign w_pause_now = 1'b0;
   assign paused      = 1'b0;
`endif

   input_repeat_counter #(
      .DAS_POLLS (DAS_POLLS),
      .ARR_POLLS (ARR_POLLS)
   ) u_rep_down (
      .clk        (clk),
      .reset      (reset),
      .tick       (buttons_valid),
      .held       (buttons[BTN_DOWN]),
      .pressed    (w_press[BTN_DOWN]),
      .inhibit    (w_pause_now),
      .repeat_evt (w_rep_down)
   );

   input_repeat_counter #(
      .DAS_POLLS (DAS_POLLS),
      .ARR_POLLS (ARR_POLLS)
   ) u_rep_left (
      .clk        (clk),
      .reset      (reset),
      .tick       (buttons_valid),
      .held       (buttons[BTN_LEFT]),
      .pressed    (w_press[BTN_LEFT]),
      .inhibit    (w_pause_now | w_lr_both),
      .repeat_evt (w_rep_left)
   );

   input_repeat_counter #(
      .DAS_POLLS (DAS_POLLS),
      .ARR_POLLS (ARR_POLLS)
   ) u_rep_right (
      .clk        (clk),
      .reset      (reset),
      .tick       (buttons_valid),
      .held       (buttons[BTN_RIGHT]),
      .pressed    (w_press[BTN_RIGHT]),
      .inhibit    (w_pause_now | w_lr_both),
      .repeat_evt (w_rep_right)
   );

   // Map press edges and repeats onto action-indexed events; pause discards all but START
   always_comb begin
      w_event                = '0;
      w_event[ACT_ROT_CW]    = w_press[BTN_A];
      w_event[ACT_ROT_CCW]   = w_press[BTN_B];
      w_event[ACT_LEFT]      = w_press[BTN_LEFT]  | w_rep_left;
      w_event[ACT_RIGHT]     = w_press[BTN_RIGHT] | w_rep_right;
      w_event[ACT_SOFT_DROP] = w_press[BTN_DOWN]  | w_rep_down;
      w_event[ACT_HARD_DROP] = w_press[BTN_UP];
      w_event[ACT_START]     = w_press[BTN_START];
      if (w_pause_now) begin
         w_event[6:1] = '0;
      end
   end

   assign w_handshake = (state_q == ST_OFFER) && action_ready;

   // Clear the accepted action first, then merge new events so a same-cycle event survives
   always_comb begin
      for (int i = 1; i < 8; i++) begin
         w_offer_mask[i] = (action_code_q == 3'(i));
      end
      pending_d = pending_q;
      if (w_handshake) begin
         pending_d = pending_d & ~w_offer_mask;
      end
      if (w_pause_now) begin
         pending_d[6:1] = '0;
      end
      pending_d = pending_d | w_event;
   end

   // Offer FSM: latch one action in IDLE, hold it stable in OFFER until accepted
   always_comb begin
      state_d        = state_q;
      action_valid_d = action_valid_q;
      action_code_d  = action_code_q;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               action_code_d  = pick_action(pending_q);
               action_valid_d = 1'b1;
               state_d        = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (action_ready) begin
               action_valid_d = 1'b0;
               action_code_d  = ACT_NONE;
               state_d        = ST_IDLE;
            end
         end
         default: begin
            action_valid_d = 1'b0;
            action_code_d  = ACT_NONE;
            state_d        = ST_IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         prev_buttons_q <= '0;
         pending_q      <= '0;
         action_valid_q <= 1'b0;
         action_code_q  <= ACT_NONE;
      end else begin
         state_q        <= state_d;
         prev_buttons_q <= prev_buttons_d;
         pending_q      <= pending_d;
         action_valid_q <= action_valid_d;
         action_code_q  <= action_code_d;
      end
   end

   assign action_valid = action_valid_q;
   assign action_code  = action_code_q;

endmodule
`default_nettype wire

// File: tb/tb_input_action_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_input_action_scheduler
// Description : Directed self-checking bench for input_action_scheduler
//               (DAS_POLLS=16, ARR_POLLS=6). Pause scenario is built when
//               INPUT_PAUSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_action_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] buttons = 8'h00;
   logic       buttons_valid = 1'b0;
   logic       action_ready = 1'b0;
   logic       action_valid;
   logic [2:0] action_code;
   logic       paused;

   int checks = 0;
   int errors = 0;
   int got[$];

   always #5 clk = ~clk;

   input_action_scheduler #(
      .DAS_POLLS (16),
      .ARR_POLLS (6)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .buttons       (buttons),
      .buttons_valid (buttons_valid),
      .action_valid  (action_valid),
      .action_code   (action_code),
      .action_ready  (action_ready),
      .paused        (paused)
   );

   // Record every accepted action; inputs only change just after rising edges
   always @(negedge clk) begin
      if (!reset && action_valid && action_ready) got.push_back(int'(action_code));
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic poll(input logic [7:0] b);
      @(posedge clk); #1;
      buttons = b;
      buttons_valid = 1'b1;
      @(posedge clk); #1;
      buttons_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cycles(3);
      checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", action_valid); end
      checks++; if (action_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", action_code); end
      checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %0b want 0", paused); end
      reset = 1'b0;
      cycles(2);
   endtask

   task automatic test_reset_mid_offer;
      got.delete();
      action_ready = 1'b0;
      poll(8'h40);
      cycles(1);
      checks++; if (action_valid !== 1'b1 || action_code !== 3'd3) begin errors++; $display("FAIL mid_offer_pre: got valid=%0b code=%0d want valid=1 code=3", action_valid, action_code); end
      reset = 1'b1;
      #1;
      checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL mid_offer_valid: got %0b want 0", action_valid); end
      checks++; if (action_code !== 3'd0) begin errors++; $display("FAIL mid_offer_code: got %0d want 0", action_code); end
      cycles(2);
      reset = 1'b0;
      action_ready = 1'b1;
      cycles(10);
      checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_offer_after: got %0d actions want 0", got.size()); end
      buttons = 8'h00;
   endtask

   task automatic test_single_press;
      got.delete();
      action_ready = 1'b1;
      poll(8'h01);
      checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%0b want 0", action_valid); end
      cycles(1);
      checks++; if (action_valid !== 1'b1 || action_code !== 3'd1) begin errors++; $display("FAIL single_offer: got valid=%0b code=%0d want valid=1 code=1", action_valid, action_code); end
      cycles(1);
      checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got valid=%0b want 0", action_valid); end
      poll(8'h00);
      cycles(4);
      checks++; if (got.size() != 1 || got[0] != 1) begin errors++; $display("FAIL single_count: got %0d actions (first %0d) want 1 of code 1", got.size(), (got.size() > 0) ? got[0] : -1); end
   endtask

   task automatic test_left_repeat;
      got.delete();
      action_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         poll(8'h40);
         if (i == 15) begin
            cycles(4);
            checks++; if (got.size() != 1) begin errors++; $display("FAIL das_before: got %0d actions after poll 15 want 1", got.size()); end
         end
         if (i == 21) begin
            cycles(2);
            checks++; if (got.size() != 2) begin errors++; $display("FAIL arr_before: got %0d actions after poll 21 want 2", got.size()); end
         end
      end
      poll(8'h00);
      cycles(6);
      checks++; if (got.size() != 4) begin errors++; $display("FAIL repeat_count: got %0d actions want 4", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] != 3) begin errors++; $display("FAIL repeat_code%0d: got %0d want 3", k, got[k]); end
      end
   endtask

   task automatic test_priority_stall;
      int exp[3] = '{6, 1, 4};
      got.delete();
      action_ready = 1'b0;
      poll(8'h91);
      cycles(1);
      for (int k = 0; k < 5; k++) begin
         checks++; if (action_valid !== 1'b1 || action_code !== 3'd6) begin errors++; $display("FAIL stall_hold%0d: got valid=%0b code=%0d want valid=1 code=6", k, action_valid, action_code); end
         cycles(1);
      end
      action_ready = 1'b1;
      cycles(10);
      checks++; if (got.size() != 3) begin errors++; $display("FAIL prio_count: got %0d actions want 3", got.size()); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (got.size() <= k || got[k] != exp[k]) begin errors++; $display("FAIL prio_order%0d: got %0d want %0d", k, (got.size() > k) ? got[k] : -1, exp[k]); end
      end
      poll(8'h00);
   endtask

   task automatic test_coalesce_and_lr;
      got.delete();
      action_ready = 1'b0;
      poll(8'h01);
      poll(8'h00);
      poll(8'h01);
      cycles(2);
      action_ready = 1'b1;
      poll(8'h00);
      cycles(8);
      checks++; if (got.size() != 1 || got[0] != 1) begin errors++; $display("FAIL coalesce: got %0d actions (first %0d) want 1 of code 1", got.size(), (got.size() > 0) ? got[0] : -1); end
      got.delete();
      for (int i = 0; i < 40; i++) poll(8'hC0);
      poll(8'h00);
      cycles(6);
      checks++; if (got.size() != 2) begin errors++; $display("FAIL lr_count: got %0d actions want 2", got.size()); end
      checks++; if (got.size() < 2 || got[0] != 3 || got[1] != 4) begin errors++; $display("FAIL lr_order: got %0d,%0d want 3,4", (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1); end
   endtask

   task automatic test_down_select;
      got.delete();
      action_ready = 1'b1;
      poll(8'h04);
      poll(8'h00);
      cycles(4);
      checks++; if (got.size() != 0) begin errors++; $display("FAIL select_ignored: got %0d actions want 0", got.size()); end
      for (int i = 0; i < 17; i++) poll(8'h20);
      poll(8'h00);
      cycles(6);
      checks++; if (got.size() != 2 || got[0] != 5 || got[1] != 5) begin errors++; $display("FAIL down_repeat: got %0d actions (first %0d) want 2 of code 5", got.size(), (got.size() > 0) ? got[0] : -1); end
   endtask

   task automatic test_start;
      got.delete();
      action_ready = 1'b1;
      poll(8'h08);
      cycles(3);
      checks++; if (got.size() != 1 || got[0] != 7) begin errors++; $display("FAIL start_action: got %0d actions (first %0d) want 1 of code 7", got.size(), (got.size() > 0) ? got[0] : -1); end
`ifdef INPUT_PAUSE_EN
      checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %0b want 1", paused); end
      poll(8'h00);
      poll(8'h40);
      poll(8'h00);
      cycles(6);
      checks++; if (got.size() != 1) begin errors++; $display("FAIL pause_discard: got %0d actions want 1", got.size()); end
      poll(8'h08);
      cycles(4);
      checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off: got %0b want 0", paused); end
      checks++; if (got.size() != 2 || got[1] != 7) begin errors++; $display("FAIL pause_start2: got %0d actions (second %0d) want 2 with code 7", got.size(), (got.size() > 1) ? got[1] : -1); end
`else
      checks++; if (paused !== 1'b0) begin errors++; $display("FAIL paused_tied: got %0b want 0", paused); end
`endif
      poll(8'h00);
      cycles(2);
   endtask

   initial begin
      test_reset();
      test_reset_mid_offer();
      test_single_press();
      test_left_repeat();
      test_priority_stall();
      test_coalesce_and_lr();
      test_down_select();
      test_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
